// File: rtl/sigma_pkg.sv
// Shared fetch-path types and constants.
package sigma_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; registered storage, no bypass.
module fetch_fifo import sigma_pkg::*; #(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t din_i,
   input  logic         pop_i,
   output fetch_entry_t dout_o,
   output logic [CW-1:0] count_o,
   output logic         full_o,
   output logic         empty_o
);
   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];
   // A flush wins over everything else in the same cycle.
   assign do_push = push_i & ~flush_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   // Pointer and occupancy next-state.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage write; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   // Upstream credit accounting must never push into a full, non-popping FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !flush_i && full_o && !pop_i));
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited imem requests, response buffer, redirect/flush.
module instruction_fetch import sigma_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [ILEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
);
   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   drop_q, drop_d;
   fetch_entry_t    last_q, last_d;
   fetch_entry_t    tag_din, tag_head, buf_din, buf_head;
   logic [CW-1:0]   tag_cnt, buf_cnt;
   logic            tag_full, tag_empty, buf_full, buf_empty;
   logic            req_fire, rsp_take, rsp_keep, buf_pop;
   logic            unused_sigs;

   // Tag-queue occupancy is the outstanding-request count; stale responses
   // still pop their tag so pairing stays aligned across redirects.
   assign imem_req_valid = rst_n & ~redirect_valid &
                           (({1'b0, tag_cnt} + {1'b0, buf_cnt}) < CREDITS);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign rsp_take       = rst_n & imem_rsp_valid;
   assign rsp_keep       = rsp_take & ~redirect_valid & (drop_q == '0);
   assign tag_din        = '{pc: pc_q, instr: '0};
   assign buf_din        = '{pc: tag_head.pc, instr: imem_rsp_data};
   assign if_valid       = ~buf_empty & ~redirect_valid;
   assign buf_pop        = if_valid & if_ready;
   assign if_pc          = buf_empty ? last_q.pc    : buf_head.pc;
   assign if_instr       = buf_empty ? last_q.instr : buf_head.instr;
   assign unused_sigs    = ^{tag_head.instr, tag_full, tag_empty, buf_full};

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tagq (
      .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
      .push_i(req_fire), .din_i(tag_din), .pop_i(rsp_take),
      .dout_o(tag_head), .count_o(tag_cnt), .full_o(tag_full), .empty_o(tag_empty)
   );

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
      .clk(clk), .rst_n(rst_n), .flush_i(redirect_valid),
      .push_i(rsp_keep), .din_i(buf_din), .pop_i(buf_pop),
      .dout_o(buf_head), .count_o(buf_cnt), .full_o(buf_full), .empty_o(buf_empty)
   );

   // PC, drop counter and held-output next-state.
   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      last_d = buf_empty ? last_q : buf_head;
      if (redirect_valid) begin
         pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
         // Everything in flight is stale; a response landing now is already gone.
         drop_d = tag_cnt - (rsp_take ? CW'(1) : CW'(0));
      end else begin
         if (req_fire) pc_d = pc_q + 32'd4;
         if (rsp_take && drop_q != '0) drop_d = drop_q - CW'(1);
      end
   end

   // Fetch-stage state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
         last_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
         last_q <= last_d;
      end
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a scoreboard-driven decode monitor.
module tb_instruction_fetch;
   import sigma_pkg::*;

   logic        clk, rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;

   int           n_chk = 0;
   int           n_fail = 0;
   fetch_entry_t expq[$];
   logic [31:0]  memq[$];
   logic         mem_hold = 1'b0;
   logic         pend = 1'b0;
   logic [31:0]  paddr = '0;
   fetch_entry_t got;

   instruction_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory image: upper half = address low bits, lower half = their inverse.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] p;
         p = start + 32'(4 * i);
         expq.push_back('{pc: p, instr: mem_word(p)});
      end
   endtask

   task automatic wait_sz(input int n, input string nm);
      int k;
      k = 0;
      while (expq.size() > n && k < 300) begin
         tick();
         k++;
      end
      chk(nm, 32'(expq.size() <= n), 32'd1);
   endtask

   // Single-cycle in-order memory; mem_hold parks responses in the queue.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst_n && imem_req_valid && imem_req_ready) memq.push_back(imem_req_addr);
         @(posedge clk);
         #2;
         if (!rst_n) memq.delete();
         if (!mem_hold && memq.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
      end
   end

   // Decode-side monitor and request-hold checker.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (pend && !redirect_valid) begin
               chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
               chk("req_hold_addr", imem_req_addr, paddr);
            end
            pend  = imem_req_valid & ~imem_req_ready;
            paddr = imem_req_addr;
            if (if_valid && if_ready) begin
               if (expq.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_instr: got pc %h, none expected", if_pc);
               end else begin
                  got = expq.pop_front();
                  chk("if_pc", if_pc, got.pc);
                  chk("if_instr", if_instr, got.instr);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; if_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);

      // Reset release and startup latency.
      push_seq(32'h0, 64);
      tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, 32'h0);
      tick(); @(negedge clk);
      chk("lat_n1_if_valid", 32'(if_valid), 32'd0);
      tick(); @(negedge clk);
      chk("lat_n2_if_valid", 32'(if_valid), 32'd1);
      wait_sz(54, "stream_progress");

      // Decode stall: buffer fills, credits run out.
      if_ready = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("stall_if_valid", 32'(if_valid), 32'd1);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_head_pc", if_pc, expq.size() > 0 ? expq[0].pc : 32'hDEAD_DEAD);
      tick(); if_ready = 1'b1;

      // Memory backpressure.
      for (int i = 0; i < 20; i++) begin
         imem_req_ready = i[0];
         tick();
      end
      imem_req_ready = 1'b1;

      // Two requests in flight, then redirect to 0x1003.
      mem_hold = 1'b1;
      repeat (6) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1003; mem_hold = 1'b0;
      expq.delete();
      push_seq(32'h0000_1000, 8);
      @(negedge clk);
      chk("redir1_if_valid", 32'(if_valid), 32'd0);
      chk("redir1_req_valid", 32'(imem_req_valid), 32'd0);
      tick(); redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir1_next_valid", 32'(imem_req_valid), 32'd1);
      chk("redir1_next_addr", imem_req_addr, 32'h0000_1000);
      wait_sz(5, "redir1_progress");

      // Fill, pop one, then redirect with a response arriving and decode ready.
      if_ready = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      chk("fill_if_valid", 32'(if_valid), 32'd1);
      chk("fill_req_valid", 32'(imem_req_valid), 32'd0);
      tick(); if_ready = 1'b1;
      tick(); if_ready = 1'b0;
      tick();
      if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      expq.delete();
      push_seq(32'hFFFF_FFF8, 8);
      @(negedge clk);
      chk("redir2_rsp_valid", 32'(imem_rsp_valid), 32'd1);
      chk("redir2_if_valid", 32'(if_valid), 32'd0);
      chk("redir2_req_valid", 32'(imem_req_valid), 32'd0);
      tick(); redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir2_next_addr", imem_req_addr, 32'hFFFF_FFF8);
      wait_sz(4, "wrap_progress");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
